// File: rtl/tm_pkg.sv
// Shared definitions for the Tsetlin-machine feedback engine: FSM encoding,
// TA state midpoint, LFSR feedback taps and saturating counter helpers.
package tm_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } tm_state_e;

  // TA state bits for the default configuration; states at or above the
  // midpoint mean "include".
  localparam int TM_STATE_WIDTH = 8;
  localparam logic [TM_STATE_WIDTH-1:0] STATE_MID = TM_STATE_WIDTH'(1) << (TM_STATE_WIDTH - 1);

  // Fibonacci feedback taps for x^24 + x^23 + x^22 + x^17 + 1 (bits 23,22,21,16).
  localparam logic [23:0] LFSR_TAPS = 24'hE1_0000;

  // Increment that sticks at ceil (operands zero-extended to 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] ceil);
    return (v >= ceil) ? ceil : v + 32'd1;
  endfunction

  // Decrement that sticks at floor (operands zero-extended to 32 bits).
  function automatic logic [31:0] sat_dec(input logic [31:0] v, input logic [31:0] floor);
    return (v <= floor) ? floor : v - 32'd1;
  endfunction

endpackage

// File: rtl/tm_lfsr.sv
// Fibonacci LFSR random source; advances one step per cycle while step is high.
module tm_lfsr
  import tm_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 24,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = LFSR_WIDTH'(24'h00ACE1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  output logic [LFSR_WIDTH-1:0] value
);

  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(LFSR_TAPS);

  logic [LFSR_WIDTH-1:0] r_value;
  logic                  w_fb;

  // Feedback bit is the parity of the tapped positions.
  always_comb begin
    w_fb = ^(r_value & TAPS);
  end

  // Shift register: reload seed on reset, shift left on step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= LFSR_SEED;
    end else if (step) begin
      r_value <= {r_value[LFSR_WIDTH-2:0], w_fb};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/tm_feedback_engine.sv
// Sequential Tsetlin-machine feedback engine: walks every clause of a class,
// read-modify-writes its TA-state row and updates its clause weight.
//
// Handshake: start is a one-cycle request accepted only in IDLE; busy is high
// from the next cycle until the DONE cycle, where done pulses for one cycle.
// State memory: st_rd_en/st_rd_addr request a row whose data must be present
// on st_rd_data in the following cycle; st_wr_en/st_wr_addr/st_wr_data commit
// the updated row in that same following cycle. Both strobes are forced low
// while rst is high so an aborted pass never writes.
module tm_feedback_engine
  import tm_pkg::*;
#(
  parameter int                    CLAUSE_NUM   = 16,
  parameter int                    LITERAL_NUM  = 32,
  parameter int                    STATE_WIDTH  = 8,
  parameter int                    WEIGHT_WIDTH = 8,
  parameter int                    PROB_WIDTH   = 8,
  parameter int                    LFSR_WIDTH   = 24,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = LFSR_WIDTH'(24'h00ACE1),
  localparam int                   AW           = (CLAUSE_NUM > 1) ? $clog2(CLAUSE_NUM) : 1,
  localparam int                   RW           = LITERAL_NUM * STATE_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             fb_type,
  input  logic [CLAUSE_NUM-1:0]            fb_mask,
  input  logic [CLAUSE_NUM-1:0]            clause_out,
  input  logic [LITERAL_NUM-1:0]           literals,
  input  logic [PROB_WIDTH-1:0]            s_prob,
  output logic                             busy,
  output logic                             done,
  output logic [AW-1:0]                    st_rd_addr,
  output logic                             st_rd_en,
  input  logic [RW-1:0]                    st_rd_data,
  output logic                             st_wr_en,
  output logic [AW-1:0]                    st_wr_addr,
  output logic [RW-1:0]                    st_wr_data,
  output logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0] weight_out
);

  localparam logic [STATE_WIDTH-1:0]  STATE_MAX  = '1;
  localparam logic [WEIGHT_WIDTH-1:0] WEIGHT_MAX = '1;
  localparam logic [AW-1:0]           LAST_C     = AW'(CLAUSE_NUM - 1);

  tm_state_e                r_state;
  logic [AW-1:0]            r_c;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_type;
  logic [CLAUSE_NUM-1:0]    r_mask;
  logic [CLAUSE_NUM-1:0]    r_clause;
  logic [LITERAL_NUM-1:0]   r_lits;
  logic [PROB_WIDTH-1:0]    r_s_prob;
  logic [WEIGHT_WIDTH-1:0]  r_weight [CLAUSE_NUM];

  logic [LFSR_WIDTH-1:0]    w_lfsr;
  logic                     w_rand;
  logic                     w_hit;
  logic                     w_last;
  logic [STATE_WIDTH-1:0]   w_s;
  logic [STATE_WIDTH-1:0]   w_s_next;
  logic [RW-1:0]            w_row_next;
  logic [WEIGHT_WIDTH-1:0]  w_weight_next;

  // One random draw per clause, advanced only while updating a clause.
  tm_lfsr #(
    .LFSR_WIDTH(LFSR_WIDTH),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (r_state == S_UPDATE),
    .value(w_lfsr)
  );

  // Per-clause decode shared by row and weight update.
  always_comb begin
    w_rand = (PROB_WIDTH'(w_lfsr) < r_s_prob);
    w_hit  = r_clause[r_c];
    w_last = (r_c == LAST_C);
  end

  // Apply Type I / Type II feedback to every TA in the row just read.
  always_comb begin
    w_row_next = st_rd_data;
    w_s        = '0;
    w_s_next   = '0;
    for (int j = 0; j < LITERAL_NUM; j++) begin
      w_s      = st_rd_data[j*STATE_WIDTH +: STATE_WIDTH];
      w_s_next = w_s;
      if (r_type) begin
        if (w_hit && r_lits[j]) begin
          w_s_next = STATE_WIDTH'(sat_inc(32'(w_s), 32'(STATE_MAX)));
        end else if (w_rand) begin
          w_s_next = STATE_WIDTH'(sat_dec(32'(w_s), 32'd0));
        end
      end else if (w_hit && !r_lits[j] && !w_s[STATE_WIDTH-1]) begin
        w_s_next = STATE_WIDTH'(sat_inc(32'(w_s), 32'(STATE_MAX)));
      end
      w_row_next[j*STATE_WIDTH +: STATE_WIDTH] = w_s_next;
    end
  end

  // Weight rewards clause firing on Type I and penalises it on Type II.
  always_comb begin
    if (r_type) begin
      w_weight_next = WEIGHT_WIDTH'(sat_inc(32'(r_weight[r_c]), 32'(WEIGHT_MAX)));
    end else begin
      w_weight_next = WEIGHT_WIDTH'(sat_dec(32'(r_weight[r_c]), 32'd1));
    end
  end

  // Pass sequencer: latch the sample, walk clauses, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_c      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_type   <= 1'b0;
      r_mask   <= '0;
      r_clause <= '0;
      r_lits   <= '0;
      r_s_prob <= '0;
      for (int i = 0; i < CLAUSE_NUM; i++) begin
        r_weight[i] <= WEIGHT_WIDTH'(1);
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_type   <= fb_type;
            r_mask   <= fb_mask;
            r_clause <= clause_out;
            r_lits   <= literals;
            r_s_prob <= s_prob;
            r_c      <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (r_mask[r_c]) begin
            r_state <= S_UPDATE;
          end else if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_c <= r_c + AW'(1);
          end
        end
        S_UPDATE: begin
          if (w_hit) begin
            r_weight[r_c] <= w_weight_next;
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_c     <= r_c + AW'(1);
            r_state <= S_READ;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Flatten weights onto the output bus, clause c in slice c.
  always_comb begin
    weight_out = '0;
    for (int c = 0; c < CLAUSE_NUM; c++) begin
      weight_out[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = r_weight[c];
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign st_rd_addr = r_c;
  assign st_wr_addr = r_c;
  assign st_rd_en   = !rst && (r_state == S_READ) && r_mask[r_c];
  assign st_wr_en   = !rst && (r_state == S_UPDATE);
  assign st_wr_data = w_row_next;

endmodule

// File: tb/tb_tm_feedback_engine.sv
// Directed bench for tm_feedback_engine with a behavioural state-memory,
// a reference model of rows/weights/LFSR and hand-computed spot values.
module tb_tm_feedback_engine;
  import tm_pkg::*;

  localparam int          CN   = 4;
  localparam int          LN   = 8;
  localparam int          SW   = 8;
  localparam int          WW   = 8;
  localparam int          PW   = 8;
  localparam int          LW   = 24;
  localparam int          RW   = LN * SW;
  localparam logic [23:0] SEED = 24'h00ACE1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             fb_type;
  logic [CN-1:0]    fb_mask;
  logic [CN-1:0]    clause_out;
  logic [LN-1:0]    literals;
  logic [PW-1:0]    s_prob;
  logic             busy;
  logic             done;
  logic [1:0]       st_rd_addr;
  logic             st_rd_en;
  logic [RW-1:0]    st_rd_data;
  logic             st_wr_en;
  logic [1:0]       st_wr_addr;
  logic [RW-1:0]    st_wr_data;
  logic [CN*WW-1:0] weight_out;

  // clock / reset
  always #5 clk = ~clk;

  tm_feedback_engine #(
    .CLAUSE_NUM  (CN),
    .LITERAL_NUM (LN),
    .STATE_WIDTH (SW),
    .WEIGHT_WIDTH(WW),
    .PROB_WIDTH  (PW),
    .LFSR_WIDTH  (LW),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fb_type   (fb_type),
    .fb_mask   (fb_mask),
    .clause_out(clause_out),
    .literals  (literals),
    .s_prob    (s_prob),
    .busy      (busy),
    .done      (done),
    .st_rd_addr(st_rd_addr),
    .st_rd_en  (st_rd_en),
    .st_rd_data(st_rd_data),
    .st_wr_en  (st_wr_en),
    .st_wr_addr(st_wr_addr),
    .st_wr_data(st_wr_data),
    .weight_out(weight_out)
  );

  // behavioural TA-state RAM, one-cycle read latency
  logic [RW-1:0] mem [CN];
  always @(posedge clk) begin
    if (st_rd_en) st_rd_data <= mem[st_rd_addr];
    if (st_wr_en) mem[st_wr_addr] <= st_wr_data;
  end

  // reference model state
  logic [RW-1:0] m_mem [CN];
  logic [WW-1:0] m_w [CN];
  logic [LW-1:0] m_lfsr;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard compare
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] v);
    logic fb;
    fb = v[23] ^ v[22] ^ v[21] ^ v[16];
    return {v[22:0], fb};
  endfunction

  function automatic logic [CN*WW-1:0] pack_w();
    logic [CN*WW-1:0] p;
    for (int c = 0; c < CN; c++) p[c*WW +: WW] = m_w[c];
    return p;
  endfunction

  // Apply one pass to the model
  task automatic model_pass(input logic t, input logic [CN-1:0] mk, input logic [CN-1:0] cl,
                            input logic [LN-1:0] lt, input logic [PW-1:0] sp);
    for (int c = 0; c < CN; c++) begin
      if (mk[c]) begin
        bit r;
        r = (m_lfsr[PW-1:0] < sp);
        for (int j = 0; j < LN; j++) begin
          int s;
          s = int'(m_mem[c][j*SW +: SW]);
          if (t) begin
            if (cl[c] && lt[j]) s = (s == 255) ? 255 : s + 1;
            else if (r)         s = (s == 0) ? 0 : s - 1;
          end else if (cl[c] && !lt[j] && s < 128) begin
            s = s + 1;
          end
          m_mem[c][j*SW +: SW] = SW'(s);
        end
        if (cl[c]) begin
          if (t) m_w[c] = (m_w[c] == 8'd255) ? 8'd255 : m_w[c] + 8'd1;
          else   m_w[c] = (m_w[c] == 8'd1) ? 8'd1 : m_w[c] - 8'd1;
        end
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  endtask

  // driver: one full pass, then compare against the model
  task automatic run_pass(input string tag, input logic t, input logic [CN-1:0] mk,
                          input logic [CN-1:0] cl, input logic [LN-1:0] lt,
                          input logic [PW-1:0] sp, input bit extra_start);
    int n, rd, wr, en;
    bit got;
    @(posedge clk); #1;
    fb_type = t; fb_mask = mk; clause_out = cl; literals = lt; s_prob = sp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; rd = 0; wr = 0; got = 0;
    for (int k = 0; k < 200; k++) begin
      if (extra_start) start = (n == 2);
      if (st_rd_en) rd++;
      if (st_wr_en) wr++;
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    en = $countones(mk);
    model_pass(t, mk, cl, lt, sp);
    check({tag, " done_seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(n), 64'((CN - en) + 2 * en + 1));
    check({tag, " rd_count"}, 64'(rd), 64'(en));
    check({tag, " wr_count"}, 64'(wr), 64'(en));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    for (int c = 0; c < CN; c++) check($sformatf("%s row%0d", tag, c), mem[c], m_mem[c]);
    check({tag, " weights"}, 64'(weight_out), 64'(pack_w()));
    check({tag, " lfsr"}, 64'(dut.u_lfsr.value), 64'(m_lfsr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [RW-1:0] snap [CN];
    logic [RW-1:0] row2_before;
    int cnt;
    bit found;

    rst = 1'b1; start = 1'b0; fb_type = 1'b0; fb_mask = '0; clause_out = '0;
    literals = '0; s_prob = '0; st_rd_data = '0;
    for (int c = 0; c < CN; c++) mem[c] = {LN{STATE_MID}};
    mem[1] = 64'h9010_9010_9010_9010;
    mem[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < CN; c++) begin
      m_mem[c] = mem[c];
      m_w[c]   = 8'd1;
    end
    m_lfsr = SEED;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst rd_en", 64'(st_rd_en), 64'd0);
    check("rst wr_en", 64'(st_wr_en), 64'd0);
    check("rst rd_addr", 64'(st_rd_addr), 64'd0);
    check("rst wr_addr", 64'(st_wr_addr), 64'd0);
    check("rst weights", 64'(weight_out), 64'h0101_0101);
    check("rst lfsr", 64'(dut.u_lfsr.value), 64'h00ACE1);
    rst = 1'b0;

    // Type I promotion/demotion on clause 0
    run_pass("t1", 1'b1, 4'b0001, 4'b0001, 8'hAA, 8'd255, 1'b0);
    check("t1 hand row0", mem[0], 64'h817F_817F_817F_817F);
    check("t1 hand w0", 64'(weight_out[7:0]), 64'd2);

    // Type II on clause 1, never random
    run_pass("t2", 1'b0, 4'b0010, 4'b0010, 8'h00, 8'd0, 1'b0);
    check("t2 hand row1", mem[1], 64'h9011_9011_9011_9011);
    check("t2 hand w1", 64'(weight_out[15:8]), 64'd1);

    // state saturation at all-ones
    run_pass("sat", 1'b1, 4'b0100, 4'b0100, 8'hFF, 8'd255, 1'b0);
    check("sat hand row2", mem[2], 64'hFFFF_FFFF_FFFF_FFFF);

    // weight saturation over 300 passes on clause 3
    for (int p = 0; p < 300; p++) run_pass("wsat", 1'b1, 4'b1000, 4'b1000, 8'hFF, 8'd255, 1'b0);
    check("wsat hand w3", 64'(weight_out[31:24]), 64'd255);

    // all clauses masked, extra start while busy is ignored
    run_pass("skip", 1'b1, 4'b0000, 4'b1111, 8'hFF, 8'd255, 1'b1);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("skip no_extra_pass", 64'(cnt), 64'd0);

    // random path: clause=0 with s_prob=0 leaves rows untouched
    for (int c = 0; c < CN; c++) snap[c] = mem[c];
    run_pass("rand0", 1'b1, 4'b1111, 4'b0000, 8'h3C, 8'd0, 1'b0);
    for (int c = 0; c < CN; c++) check($sformatf("rand0 hand row%0d", c), mem[c], snap[c]);
    run_pass("rand128", 1'b1, 4'b1011, 4'b0000, 8'h3C, 8'd128, 1'b0);
    run_pass("mix", 1'b0, 4'b1110, 4'b0110, 8'h5A, 8'd77, 1'b0);

    // reset during UPDATE of clause 2
    @(posedge clk); #1;
    fb_type = 1'b1; fb_mask = 4'b1111; clause_out = 4'b1111; literals = 8'h5A; s_prob = 8'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (st_wr_en && st_wr_addr == 2'd2) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rstmid reached_update2", 64'(found), 64'd1);
    row2_before = mem[2];
    rst = 1'b1;
    #1;
    check("rstmid wr_en_in_rst_cycle", 64'(st_wr_en), 64'd0);
    @(posedge clk); #1;
    check("rstmid busy", 64'(busy), 64'd0);
    check("rstmid wr_en", 64'(st_wr_en), 64'd0);
    check("rstmid rd_en", 64'(st_rd_en), 64'd0);
    check("rstmid weights", 64'(weight_out), 64'h0101_0101);
    check("rstmid row2_kept", mem[2], row2_before);
    check("rstmid lfsr", 64'(dut.u_lfsr.value), 64'h00ACE1);
    model_pass(1'b1, 4'b0011, 4'b1111, 8'h5A, 8'd200);
    for (int c = 0; c < CN; c++) m_w[c] = 8'd1;
    m_lfsr = SEED;
    check("rstmid row0", mem[0], m_mem[0]);
    check("rstmid row1", mem[1], m_mem[1]);
    rst = 1'b0;

    // clean pass after abort
    run_pass("post", 1'b1, 4'b1111, 4'b1010, 8'hC3, 8'd150, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
